// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - lane-wide coordinate widths, raster defaults, side encoding and collector states
package lane_pkg;
    localparam int COORD_W = 12;
    localparam int AXIS_W  = 24;

    localparam int IMG_W_DEF     = 1280;
    localparam int IMG_H_DEF     = 720;
    localparam int ROI_Y_TOP_DEF = 360;
    localparam int X_SPLIT_DEF   = 640;

    // Side flag values are shared with the rho/phase search stage
    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN_L,
        ST_GAP_L,
        ST_DRAIN_R,
        ST_GAP_R
    } collect_state_t;
endpackage

// File: rtl/edge_pt_ram.sv
// rtl/edge_pt_ram.sv - simple dual-port point store, one write port, registered read
module edge_pt_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/edge_point_collect.sv
// rtl/edge_point_collect.sv - captures ROI edge points per frame and replays them as left/right bursts
module edge_point_collect
    import lane_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int ROI_Y_TOP = ROI_Y_TOP_DEF,
    parameter int X_SPLIT   = X_SPLIT_DEF,
    parameter int NPTS      = 256,
    parameter int GAP       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    pix_vld,
    input  logic                    pix_edge,
    output logic                    out_vld,
    output logic [AXIS_W-1:0]       x_y_axis,
    output logic                    interest_part,
    output logic                    busy,
    output logic                    frame_drop,
    output logic [$clog2(NPTS):0]   pts_left,
    output logic [$clog2(NPTS):0]   pts_right,
    output logic                    ovf_left,
    output logic                    ovf_right
);
    localparam int AW = $clog2(NPTS);
    localparam int CW = AW + 1;
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] ROI_TOP   = COORD_W'(ROI_Y_TOP);
    localparam logic [COORD_W-1:0] X_SPLIT_C = COORD_W'(X_SPLIT);
    localparam logic [CW-1:0]      NPTS_C    = CW'(NPTS);
    localparam logic [15:0]        DRAIN_LAST = 16'(NPTS - 1);
    localparam logic [15:0]        GAP_LAST   = 16'(GAP - 1);

    collect_state_t     state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, cur_x, cur_y;
    logic [CW-1:0]      cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d, base_l, base_r;
    logic [CW-1:0]      pts_l_q, pts_l_d, pts_r_q, pts_r_d;
    logic               ovf_l_q, ovf_l_d, ovf_r_q, ovf_r_d;
    logic               povf_l_q, povf_l_d, povf_r_q, povf_r_d;
    logic [15:0]        tmr_q, tmr_d;
    logic               side_q, side_d, vld_q, vld_d, ok_q, ok_d, drop_q, drop_d;
    logic               collecting, restart, cand, is_left, last_pix, wr_l, wr_r;
    logic               in_drain, rd_side;
    logic [AW:0]        waddr, raddr;
    logic [AXIS_W-1:0]  rdata;

    // frame_start forces the coincident pixel to (0,0)
    assign cur_x    = frame_start ? '0 : x_q;
    assign cur_y    = frame_start ? '0 : y_q;
    assign in_drain = (state_q == ST_DRAIN_L) || (state_q == ST_DRAIN_R);
    assign rd_side  = (state_q == ST_DRAIN_R);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_COLLECT);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_vld) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = cur_y + COORD_W'(1);
            end else begin
                x_d = cur_x + COORD_W'(1);
                y_d = cur_y;
            end
        end else if (frame_start) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        side_d   = side_q;
        pts_l_d  = pts_l_q;
        pts_r_d  = pts_r_q;
        povf_l_d = povf_l_q;
        povf_r_d = povf_r_q;

        collecting = (state_q == ST_COLLECT) ||
                     ((state_q == ST_IDLE) && frame_start && pix_vld);
        restart  = (state_q == ST_IDLE) || frame_start;
        base_l   = restart ? '0 : cnt_l_q;
        base_r   = restart ? '0 : cnt_r_q;
        cand     = collecting && pix_vld && pix_edge && (cur_y >= ROI_TOP);
        is_left  = (cur_x < X_SPLIT_C);
        wr_l     = cand && is_left && (base_l < NPTS_C);
        wr_r     = cand && !is_left && (base_r < NPTS_C);
        cnt_l_d  = base_l + CW'(wr_l);
        cnt_r_d  = base_r + CW'(wr_r);
        ovf_l_d  = (!restart && ovf_l_q) || (cand && is_left && (base_l == NPTS_C));
        ovf_r_d  = (!restart && ovf_r_q) || (cand && !is_left && (base_r == NPTS_C));
        last_pix = collecting && pix_vld && (cur_x == X_LAST) && (cur_y == Y_LAST);

        // Pad decision travels one cycle alongside the RAM read
        vld_d  = in_drain;
        ok_d   = in_drain && (tmr_q[CW-1:0] < (rd_side ? pts_r_q : pts_l_q));
        drop_d = frame_start && busy;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (collecting) state_d = ST_COLLECT;
                if (last_pix) begin
                    state_d  = ST_DRAIN_L;
                    tmr_d    = '0;
                    side_d   = SIDE_LEFT;
                    pts_l_d  = cnt_l_d;
                    pts_r_d  = cnt_r_d;
                    povf_l_d = ovf_l_d;
                    povf_r_d = ovf_r_d;
                end
            end
            ST_DRAIN_L: begin
                tmr_d = tmr_q + 16'd1;
                if (tmr_q == DRAIN_LAST) begin
                    state_d = ST_GAP_L;
                    tmr_d   = '0;
                end
            end
            ST_GAP_L: begin
                tmr_d = tmr_q + 16'd1;
                if (tmr_q == GAP_LAST) begin
                    state_d = ST_DRAIN_R;
                    tmr_d   = '0;
                    side_d  = SIDE_RIGHT;
                end
            end
            ST_DRAIN_R: begin
                tmr_d = tmr_q + 16'd1;
                if (tmr_q == DRAIN_LAST) begin
                    state_d = ST_GAP_R;
                    tmr_d   = '0;
                end
            end
            ST_GAP_R: begin
                tmr_d = tmr_q + 16'd1;
                if (tmr_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            cnt_l_q  <= '0;
            cnt_r_q  <= '0;
            ovf_l_q  <= 1'b0;
            ovf_r_q  <= 1'b0;
            pts_l_q  <= '0;
            pts_r_q  <= '0;
            povf_l_q <= 1'b0;
            povf_r_q <= 1'b0;
            tmr_q    <= '0;
            side_q   <= 1'b0;
            vld_q    <= 1'b0;
            ok_q     <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_l_q  <= cnt_l_d;
            cnt_r_q  <= cnt_r_d;
            ovf_l_q  <= ovf_l_d;
            ovf_r_q  <= ovf_r_d;
            pts_l_q  <= pts_l_d;
            pts_r_q  <= pts_r_d;
            povf_l_q <= povf_l_d;
            povf_r_q <= povf_r_d;
            tmr_q    <= tmr_d;
            side_q   <= side_d;
            vld_q    <= vld_d;
            ok_q     <= ok_d;
            drop_q   <= drop_d;
        end
    end

    assign waddr = wr_l ? {SIDE_LEFT, base_l[AW-1:0]} : {SIDE_RIGHT, base_r[AW-1:0]};
    assign raddr = {rd_side, tmr_q[AW-1:0]};

    edge_pt_ram #(
        .ADDR_W (AW + 1),
        .DATA_W (AXIS_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_l || wr_r),
        .waddr_i (waddr),
        .wdata_i ({cur_x, cur_y}),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign out_vld       = vld_q;
    assign x_y_axis      = ok_q ? rdata : '0;
    assign interest_part = side_q;
    assign frame_drop    = drop_q;
    assign pts_left      = pts_l_q;
    assign pts_right     = pts_r_q;
    assign ovf_left      = povf_l_q;
    assign ovf_right     = povf_r_q;
endmodule

// File: tb/tb_edge_point_collect.sv
// tb/tb_edge_point_collect.sv - directed bench for edge_point_collect on a 16x8 raster
module tb_edge_point_collect;
    localparam int W = 16, H = 8, NP = 4, GP = 24;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, pix_vld, pix_edge;
    logic        out_vld, interest_part, busy, frame_drop, ovf_left, ovf_right;
    logic [23:0] x_y_axis;
    logic [2:0]  pts_left, pts_right;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          busy_seen;
    bit          inj_drop = 1'b0;
    logic [23:0] exp_l [4];
    logic [23:0] exp_r [4];

    always #5 clk = ~clk;

    edge_point_collect #(
        .IMG_W (W), .IMG_H (H), .ROI_Y_TOP (4), .X_SPLIT (8), .NPTS (NP), .GAP (GP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .pix_vld       (pix_vld),
        .pix_edge      (pix_edge),
        .out_vld       (out_vld),
        .x_y_axis      (x_y_axis),
        .interest_part (interest_part),
        .busy          (busy),
        .frame_drop    (frame_drop),
        .pts_left      (pts_left),
        .pts_right     (pts_right),
        .ovf_left      (ovf_left),
        .ovf_right     (ovf_right)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic edge_of(input int id, input int x, input int y);
        case (id)
            0: return (x == 2 && y == 5) || (x == 10 && y == 6) || (x == 3 && y == 7);
            1: return (x == 1 && y == 0) || (x == 12 && y == 2) || (x == 5 && y == 3);
            2: return (y == 4 && (x == 0 || x == 1 || x == 7)) || (x == 2 && y == 5) ||
                      (x == 6 && y == 6) || (x == 0 && y == 7);
            3: return (x == 7 && y == 4) || (x == 8 && y == 4) || (x == 15 && y == 7);
            4: return y >= 4;
            default: return 1'b0;
        endcase
    endfunction

    task automatic feed(input int id, input int first, input bit fs);
        for (int p = first; p < W * H; p++) begin
            frame_start = fs && (p == first);
            pix_vld     = 1'b1;
            pix_edge    = edge_of(id, p % W, p / W);
            step();
            busy_seen += int'(busy);
        end
        frame_start = 1'b0;
        pix_vld     = 1'b0;
        pix_edge    = 1'b0;
    endtask

    task automatic set_exp(input logic [23:0] l0, l1, l2, l3, r0, r1, r2, r3);
        exp_l[0] = l0; exp_l[1] = l1; exp_l[2] = l2; exp_l[3] = l3;
        exp_r[0] = r0; exp_r[1] = r1; exp_r[2] = r2; exp_r[3] = r3;
    endtask

    // Entered one cycle after the last pixel (T+1); leaves in IDLE
    task automatic check_bursts();
        int n_hi;
        int ip_bad;
        chk("busy_drain", busy, 1);
        chk("ip_left_first", interest_part, 0);
        chk("vld_t1", out_vld, 0);
        step();
        for (int j = 0; j < NP; j++) begin
            chk("l_vld", out_vld, 1);
            chk("l_data", x_y_axis, exp_l[j]);
            step();
        end
        n_hi = 0;
        ip_bad = 0;
        for (int g = 0; g < GP; g++) begin
            n_hi += int'(out_vld);
            if (g < GP - 1) ip_bad += int'(interest_part != 1'b0);
            else chk("ip_right_first", interest_part, 1);
            step();
        end
        chk("gap_l_vld", n_hi, 0);
        chk("gap_l_ip", ip_bad, 0);
        for (int j = 0; j < NP; j++) begin
            chk("r_vld", out_vld, 1);
            chk("r_data", x_y_axis, exp_r[j]);
            chk("r_side", interest_part, 1);
            if (inj_drop && j == 2) chk("drop_pulse", frame_drop, 1);
            if (inj_drop && j == 3) chk("drop_single", frame_drop, 0);
            if (inj_drop && j == 1) begin
                frame_start = 1'b1;
                pix_vld     = 1'b1;
                pix_edge    = 1'b1;
            end
            step();
            frame_start = 1'b0;
            pix_vld     = 1'b0;
            pix_edge    = 1'b0;
        end
        chk("r_end", out_vld, 0);
        repeat (GP - 2) step();
        chk("busy_gap_r", busy, 1);
        step();
        chk("busy_idle", busy, 0);
        chk("ip_hold_idle", interest_part, 1);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_vld = 1'b0; pix_edge = 1'b0;
        busy_seen = 0;
        repeat (3) step();
        chk("rst_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ip", interest_part, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_data", x_y_axis, 0);
        chk("rst_pts", {pts_left, pts_right}, 0);
        chk("rst_ovf", {ovf_left, ovf_right}, 0);
        rst_n = 1'b1;
        step();

        // Basic split, zero padding and burst latency
        feed(0, 0, 1'b1);
        set_exp(24'h002005, 24'h003007, 0, 0, 24'h00A006, 0, 0, 0);
        check_bursts();
        chk("a_pts_l", pts_left, 2);
        chk("a_pts_r", pts_right, 1);
        chk("a_ovf", {ovf_left, ovf_right}, 0);

        // Edges only above the ROI
        feed(1, 0, 1'b1);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        check_bursts();
        chk("b_pts_l", pts_left, 0);
        chk("b_pts_r", pts_right, 0);

        // Left overflow
        feed(2, 0, 1'b1);
        set_exp(24'h000004, 24'h001004, 24'h007004, 24'h002005, 0, 0, 0, 0);
        check_bursts();
        chk("c_pts_l", pts_left, 4);
        chk("c_pts_r", pts_right, 0);
        chk("c_ovf_l", ovf_left, 1);
        chk("c_ovf_r", ovf_right, 0);

        // Frame arriving during DRAIN_R is dropped, rest of it ignored in IDLE
        feed(0, 0, 1'b1);
        set_exp(24'h002005, 24'h003007, 0, 0, 24'h00A006, 0, 0, 0);
        inj_drop = 1'b1;
        check_bursts();
        inj_drop = 1'b0;
        busy_seen = 0;
        feed(4, 1, 1'b0);
        repeat (4) begin
            step();
            busy_seen += int'(busy);
        end
        chk("drop_ignored", busy_seen, 0);
        chk("drop_pts_l", pts_left, 2);

        // Next frame captured normally; last pixel and split boundary are candidates
        feed(3, 0, 1'b1);
        set_exp(24'h007004, 0, 0, 0, 24'h008004, 24'h00F007, 0, 0);
        check_bursts();
        chk("e_pts_l", pts_left, 1);
        chk("e_pts_r", pts_right, 2);

        // Reset in the middle of DRAIN_L
        feed(0, 0, 1'b1);
        repeat (3) step();
        chk("pre_rst_vld", out_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ip", interest_part, 0);
        chk("mid_rst_pts", pts_left, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        feed(3, 0, 1'b1);
        set_exp(24'h007004, 0, 0, 0, 24'h008004, 24'h00F007, 0, 0);
        check_bursts();
        chk("f_pts_r", pts_right, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/edge_point_collect.md
Name: edge_point_collect

Overview:
Upstream feeder for the per-side rho/phase search stage.
- Watches the binarised edge-pixel raster and captures up to NPTS edge coordinates per frame inside the lower ROI, split into a left half and a right half.
- After frame end, streams them out as two fixed-length bursts of exactly NPTS valid beats: left first, then right.
- Holds interest_part stable through each burst plus a drain gap, so the downstream search pipeline sees a constant side flag until its result emerges.

Parameters:
IMG_W, 1280, active pixels per line
IMG_H, 720, active lines per frame
ROI_Y_TOP, 360, first line (inclusive) of the region of interest
X_SPLIT, 640, x < X_SPLIT is left, otherwise right
NPTS, 256, beats per burst; power of two, at most 2048
GAP, 32, idle cycles after each burst; must be at least 24 (18 calc + 5 compare + 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, coincident with the first pixel of a frame
pix_vld  in  1  active pixel strobe, raster order
pix_edge  in  1  edge flag for the current pixel
out_vld  out  1  coordinate beat valid
x_y_axis  out  24  [23:12] x, [11:0] y
interest_part  out  1  0 = left burst, 1 = right burst
busy  out  1  high in any state other than IDLE/COLLECT
frame_drop  out  1  one-cycle pulse when a frame is ignored
pts_left  out  log2(NPTS)+1  left points captured in the last frame, saturated at NPTS
pts_right  out  log2(NPTS)+1  right points captured in the last frame, saturated at NPTS
ovf_left  out  1  more than NPTS left candidates in the last frame
ovf_right  out  1  more than NPTS right candidates in the last frame

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - point counters 0
- Raster counters x, y (12 bit):
  - frame_start loads x=0, y=0 for the coincident pixel.
  - Each pix_vld advances x; at x=IMG_W-1, x wraps to 0 and y increments.
- State machine: IDLE -> COLLECT -> DRAIN_L -> GAP_L -> DRAIN_R -> GAP_R -> IDLE.
  - IDLE: waits for frame_start together with pix_vld; enters COLLECT and clears cntL/cntR in that same cycle. That first pixel is evaluated normally.
  - COLLECT: a pixel is a candidate when pix_vld, pix_edge, and y >= ROI_Y_TOP.
    - Left candidate (x < X_SPLIT): if cntL < NPTS, write {x,y} to RAM address {0,cntL} and increment cntL; otherwise set the left overflow flag.
    - Right candidates are handled symmetrically at address {1,cntR}.
    - On acceptance of pixel (IMG_W-1, IMG_H-1): latch pts_*/ovf_* and go to DRAIN_L.
    - A frame_start during COLLECT restarts collection: counters are cleared and the current pixel is (0,0). No frame_drop.
  - DRAIN_L: interest_part=0 from the first cycle. Read index i runs 0..NPTS-1, one per cycle. RAM read latency is 1 cycle.
    - out_vld is high for exactly NPTS consecutive cycles, the first one 2 cycles after the last-pixel cycle.
    - x_y_axis = RAM data when i < pts_left, else 24'd0 (zero pad). The i < pts compare is pipelined alongside the RAM read.
  - GAP_L: GAP cycles with out_vld=0; interest_part holds at 0.
  - DRAIN_R and GAP_R: identical, using bank 1 and pts_right, with interest_part=1.
    - interest_part changes only on the first cycle of DRAIN_L or DRAIN_R.
    - interest_part stays 1 after returning to IDLE.
- Frame handling while busy: a frame_start that arrives while busy=1 produces a frame_drop pulse, and that whole frame is ignored (no RAM writes).
  - Return to IDLE is gated: the next accepted frame is the next frame_start seen in IDLE.
- Zero-candidate side: still emits NPTS beats of 24'd0.
- Reset mid-operation: everything returns to reset values immediately; RAM contents are don't-care because the counters are cleared.

Decomposition:
- Shared package lane_pkg:
  - COORD_W=12 and AXIS_W=24
  - IMG_W/IMG_H/ROI defaults
  - side encoding LEFT=0, RIGHT=1, shared with the rho stage
  - FSM state enum
- Sub-module edge_pt_ram: simple dual-port RAM, 2*NPTS x 24, one write port, registered read (1-cycle latency), no reset on the array.

Test Plan:
- 16x8 raster, ROI_Y_TOP=4, X_SPLIT=8, NPTS=4, GAP=24; edges at (2,5),(10,6),(3,7) -> left burst (2,5),(3,7),0,0; then 24 idle cycles; then interest_part=1 and right burst (10,6),0,0,0; pts_left=2, pts_right=1.
- Edge pixels only at y<ROI_Y_TOP -> both bursts are all-zero, 4 beats each; pts_left=pts_right=0.
- 6 left candidates with NPTS=4 -> first 4 emitted in raster order; pts_left=4, ovf_left=1, ovf_right=0.
- frame_start asserted during DRAIN_R -> frame_drop for 1 cycle; the right burst completes unchanged; no writes from that frame; the following frame is captured normally.
- Latency check: last pixel at cycle T -> out_vld first high at T+2, burst runs continuously for NPTS cycles, and the right burst starts at T+2+NPTS+GAP.
- Assert rst_n low mid DRAIN_L -> out_vld, interest_part, and busy are 0 the same cycle; after release, state is IDLE and the next frame behaves normally.
